neuron_input_buffer: RTL
========================

Name: neuron_input_buffer

Overview:
Upstream stage of `neuron`. Collects a serial stream of fixed-point samples, one word per accepted handshake, into a NUM_INPUTS-entry parallel vector. Presents the vector on `inputs` with `inputs_ready` and holds it stable until the neuron signals completion on `output_ready`. Sits between the sample source (image loader or previous layer serialiser) and each neuron/layer.

Parameters:
- NUM_INPUTS, default 120: number of samples per vector; must be >= 2.
- Fixed-point format comes from the package constants INTEGER_WIDTH and FRACTION_WIDTH.
- Each word is signed [INTEGER_WIDTH-1:-FRACTION_WIDTH].
- Derived localparam COUNT_WIDTH = $clog2(NUM_INPUTS).

Ports:
- clock  in  1  rising-edge system clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous abort; discards partial or presented vector, returns to FILL.
- in_valid  in  1  source has a word on in_data.
- in_ready  out  1  buffer accepts in_data this cycle.
- in_data  in  INTEGER_WIDTH+FRACTION_WIDTH  sample word (8 bits when PIXEL_NORMALISE_EN is defined).
- inputs  out  NUM_INPUTS x signed [INTEGER_WIDTH-1:-FRACTION_WIDTH]  parallel vector to neuron.
- inputs_ready  out  1  vector complete and stable.
- output_ready  in  1  neuron result done; releases the vector.
- count  out  COUNT_WIDTH+1  number of words stored in the current vector.

Behaviour:
- Reset (reset low, async):
  - state=FILL; count=0; all inputs entries=0; inputs_ready=0.
  - in_ready=1 after reset deasserts.
- in_ready is combinational: (state==FILL) && !clear.
- Accept = in_valid && in_ready. On accept, inputs[count] <= in_data and count++.
- FILL:
  - An accept while count==NUM_INPUTS-1 moves to PRESENT.
  - inputs_ready is registered and rises on the next clock, i.e. 1 cycle after the last accept.
  - Minimum fill latency: NUM_INPUTS cycles of accepts.
  - output_ready is ignored in FILL.
- PRESENT:
  - inputs_ready=1, in_ready=0, inputs frozen.
  - in_valid is ignored; no overwrite.
  - output_ready==1 sampled moves to DRAIN next cycle. inputs_ready falls in the same edge and count resets to 0.
- DRAIN:
  - inputs_ready=0, in_ready=0.
  - Stay until output_ready==0, then go to FILL on the next edge.
  - This guarantees a level-held output_ready from the previous vector never releases the next one.
- Entry retention: inputs entries are not zeroed between vectors, only overwritten. Entries beyond count are stale during FILL.
- clear (synchronous, any state): next edge gives state=FILL, count=0, inputs_ready=0, entries untouched.
  - clear takes priority over accept and over output_ready in the same cycle.
  - clear in DRAIN goes directly to FILL, regardless of output_ready.
- Simultaneous last accept and output_ready in FILL: the accept wins and the state goes to PRESENT. output_ready must be re-sampled in PRESENT.
- count in PRESENT reads NUM_INPUTS. It reads 0 in DRAIN.
- Illegal state encoding recovers to FILL with count=0.

Optional Feature:
PIXEL_NORMALISE_EN
- Defined:
  - in_data is 8-bit unsigned pixel p.
  - Stored word has integer bits=0, fraction bits [-1:-8]=p, and the remaining lower fraction bits=0, i.e. value p/256.
  - If FRACTION_WIDTH<8, the pixel is truncated to its top FRACTION_WIDTH bits.
- Undefined: in_data is the full signed fixed-point word, stored unchanged.

Test Plan:
- Reset then fill, NUM_INPUTS=4, every word=3.0 (integer 3, fraction 0), in_valid held high:
  - in_ready high for 4 cycles.
  - inputs_ready rises on cycle 5.
  - all four inputs read 3.0, count=4.
- Backpressure: with the vector presented, drive 5 more in_valid words:
  - in_ready=0 throughout.
  - inputs unchanged; word 0 is still 3.0.
- Release handshake:
  - output_ready=1 for 3 cycles: inputs_ready falls after the first edge; the state stays in DRAIN while output_ready is high.
  - in_ready returns 1 cycle after output_ready drops.
  - A new vector of values 1..4 then loads in order.
- Gapped source: in_valid toggles every other cycle for NUM_INPUTS=4:
  - count steps 0,1,2,3 only on accepts.
  - inputs_ready rises 1 cycle after the 4th accept.
- clear mid-fill after 2 words, and again in PRESENT:
  - count goes to 0, inputs_ready goes to 0, in_ready goes to 1 next cycle.
  - The following 4 accepts produce a correct vector.
- Async reset asserted mid-PRESENT, between clock edges:
  - inputs_ready and inputs go to 0 immediately.
  - With PIXEL_NORMALISE_EN defined, pixel 0x80 stores as 0.5.

Source files
------------

// File: rtl/neuron_input_buffer.sv
// Serial-to-parallel input buffer for a neuron: gathers NUM_INPUTS fixed-point words
// and holds them until released. Optional macro PIXEL_NORMALISE_EN stores 8-bit pixels as p/256.
package neuron_pkg;
    localparam int INTEGER_WIDTH  = 8;
    localparam int FRACTION_WIDTH = 8;
endpackage

module neuron_input_buffer
    import neuron_pkg::*;
#(
    parameter  int NUM_INPUTS  = 120,
    localparam int COUNT_WIDTH = $clog2(NUM_INPUTS)
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      clear,
    input  logic                                      in_valid,
    output logic                                      in_ready,
`ifdef PIXEL_NORMALISE_EN
    input  logic [7:0]                                in_data,
`else
    input  logic [INTEGER_WIDTH+FRACTION_WIDTH-1:0]   in_data,
`endif
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] inputs [NUM_INPUTS],
    output logic                                      inputs_ready,
    input  logic                                      output_ready,
    output logic [COUNT_WIDTH:0]                      count
);

    localparam int WORD_WIDTH = INTEGER_WIDTH + FRACTION_WIDTH;
    localparam logic [COUNT_WIDTH:0] LAST_INDEX = (COUNT_WIDTH + 1)'(NUM_INPUTS - 1);

    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] word_t;
    typedef enum logic [1:0] {
        FILL    = 2'b00,
        PRESENT = 2'b01,
        DRAIN   = 2'b10
    } state_t;

    state_t state;
    state_t state_next;
    logic   accept;

`ifdef PIXEL_NORMALISE_EN
    localparam int PIXEL_SHL = (FRACTION_WIDTH >= 8) ? FRACTION_WIDTH - 8 : 0;
    localparam int PIXEL_SHR = (FRACTION_WIDTH >= 8) ? 0 : 8 - FRACTION_WIDTH;

    // Pixel lands in the top fraction bits; narrower fractions keep only its MSBs.
    function automatic word_t to_word(input logic [7:0] pixel);
        return word_t'(WORD_WIDTH'(pixel >> PIXEL_SHR) << PIXEL_SHL);
    endfunction
`else
    function automatic word_t to_word(input logic [WORD_WIDTH-1:0] raw);
        return word_t'(raw);
    endfunction
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // DRAIN waits for output_ready to drop so a level-held release cannot free the next vector.
    always_comb begin
        state_next = FILL;
        if (!clear) begin
            case (state)
                FILL:    state_next = (accept && count == LAST_INDEX) ? PRESENT : FILL;
                PRESENT: state_next = output_ready ? DRAIN : PRESENT;
                DRAIN:   state_next = output_ready ? DRAIN : FILL;
                default: state_next = FILL;
            endcase
        end
    end

    always_comb begin
        in_ready = (state == FILL) && !clear;
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inputs_ready <= 1'b0;
        end else begin
            inputs_ready <= (state_next == PRESENT);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            case (state)
                FILL:    if (accept) count <= count + (COUNT_WIDTH + 1)'(1);
                PRESENT: if (output_ready) count <= '0;
                default: count <= '0;
            endcase
        end
    end

    // Entries are only overwritten, never cleared between vectors.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                inputs[i] <= '0;
            end
        end else if (accept) begin
            inputs[count[COUNT_WIDTH-1:0]] <= to_word(in_data);
        end
    end

endmodule
